// File: rtl/multicycle_ctrl_if.sv
// Signal bundle between the multi-cycle MIPS sequencer and its datapath/memory.
// The controller uses the master view; the datapath/memory side uses the slave view.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             mem_ready;
    logic             mem_req;
    logic             memwrite;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [2:0]       op;
    logic             regwrite;
    logic             regdst;
    logic             mem2reg;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr,
        input  mem_ready,
        output mem_req,
        output memwrite,
        output iord,
        output ir_write,
        output pc_write,
        output alusrca,
        output alusrcb,
        output op,
        output regwrite,
        output regdst,
        output mem2reg,
        output illegal,
        output bus_err,
        output retired
    );

    modport slave (
        output instr,
        output mem_ready,
        input  mem_req,
        input  memwrite,
        input  iord,
        input  ir_write,
        input  pc_write,
        input  alusrca,
        input  alusrcb,
        input  op,
        input  regwrite,
        input  regdst,
        input  mem2reg,
        input  illegal,
        input  bus_err,
        input  retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: steps each instruction through fetch/decode/execute/memory/
// writeback over one shared memory port, with a per-request memory wait timeout.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_FETCH  | read instruction at PC, PC+4 computed; IR/PC load on mem_ready
//   S_DECODE | classify opcode/funct, route to execute path or HALT
//   S_EXEC_R | R-type ALU operation rs op rt
//   S_EXEC_I | addi: rs + sign-extended immediate
//   S_ADDR   | lw/sw effective address: rs + sign-extended immediate
//   S_MEMRD  | lw data read at ALUOut
//   S_MEMWR  | sw data write at ALUOut, retires on completion
//   S_WB_R   | write ALUOut to rd, retire
//   S_WB_I   | write ALUOut to rt, retire
//   S_WB_MEM | write memory data to rt, retire
//   S_HALT   | illegal instruction or memory timeout; only reset leaves
module multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam bit TO_EN  = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT  = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ADDR,
        S_MEMRD,
        S_MEMWR,
        S_WB_R,
        S_WB_I,
        S_WB_MEM,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    assign opcode            = bus.instr[31:26];
    assign funct             = bus.instr[5:0];
    assign unused_instr_bits = ^bus.instr[25:6];

    logic       r_legal;
    logic [2:0] r_op;

    always_comb begin
        r_legal = 1'b1;
        r_op    = ALU_ADD;
        case (funct)
            FN_ADD:  r_op = ALU_ADD;
            FN_AND:  r_op = ALU_AND;
            FN_OR:   r_op = ALU_OR;
            FN_SUB:  r_op = ALU_SUB;
            FN_SLT:  r_op = ALU_SLT;
            default: r_legal = 1'b0;
        endcase
    end

    // A stalled request times out on the cycle the counter reaches MEM_TIMEOUT-1,
    // unless mem_ready arrives in that same cycle.
    logic in_mem_state;
    logic mem_stall;
    logic mem_timeout;

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign mem_stall    = in_mem_state && !bus.mem_ready;
    assign mem_timeout  = TO_EN && mem_stall && (wait_q == WAIT_LAST);

    logic       mem_req_c;
    logic       memwrite_c;
    logic       iord_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic       alusrca_c;
    logic [1:0] alusrcb_c;
    logic [2:0] op_c;
    logic       regwrite_c;
    logic       regdst_c;
    logic       mem2reg_c;
    logic       retire;

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        retire     = 1'b0;
        mem_req_c  = 1'b0;
        memwrite_c = 1'b0;
        iord_c     = 1'b0;
        ir_write_c = 1'b0;
        pc_write_c = 1'b0;
        alusrca_c  = 1'b0;
        alusrcb_c  = SRCB_RT;
        op_c       = ALU_ADD;
        regwrite_c = 1'b0;
        regdst_c   = 1'b0;
        mem2reg_c  = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alusrcb_c = SRCB_4;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (mem_timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_DECODE: begin
                if (opcode == OPC_RTYPE && r_legal) begin
                    state_d = S_EXEC_R;
                end else if (opcode == OPC_ADDI) begin
                    state_d = S_EXEC_I;
                end else if (opcode == OPC_LW || opcode == OPC_SW) begin
                    state_d = S_ADDR;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC_R: begin
                alusrca_c = 1'b1;
                alusrcb_c = SRCB_RT;
                op_c      = r_op;
                state_d   = S_WB_R;
            end
            S_EXEC_I: begin
                alusrca_c = 1'b1;
                alusrcb_c = SRCB_IMM;
                state_d   = S_WB_I;
            end
            S_ADDR: begin
                alusrca_c = 1'b1;
                alusrcb_c = SRCB_IMM;
                state_d   = (opcode == OPC_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (mem_timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_MEMWR: begin
                mem_req_c  = 1'b1;
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (mem_timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_WB_R: begin
                regwrite_c = 1'b1;
                regdst_c   = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_WB_I: begin
                regwrite_c = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_WB_MEM: begin
                regwrite_c = 1'b1;
                mem2reg_c  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Saturating so that a disabled timeout never wraps back into a stale compare.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_stall && wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Gating with rst keeps the Mealy write enables from pulsing while reset is applied.
    assign bus.mem_req  = mem_req_c & ~rst;
    assign bus.memwrite = memwrite_c & ~rst;
    assign bus.iord     = iord_c & ~rst;
    assign bus.ir_write = ir_write_c & ~rst;
    assign bus.pc_write = pc_write_c & ~rst;
    assign bus.alusrca  = alusrca_c & ~rst;
    assign bus.alusrcb  = alusrcb_c & {2{~rst}};
    assign bus.op       = op_c & {3{~rst}};
    assign bus.regwrite = regwrite_c & ~rst;
    assign bus.regdst   = regdst_c & ~rst;
    assign bus.mem2reg  = mem2reg_c & ~rst;
    assign bus.illegal  = illegal_q;
    assign bus.bus_err  = bus_err_q;
    assign bus.retired  = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus randomized instruction streams,
// checked cycle by cycle against a phase-list model of each instruction class.
module tb_multicycle_ctrl;
    localparam int CNT_W = 4;
    localparam int TO    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef enum int {P_FETCH, P_DEC, P_EXR, P_EXI, P_ADDR, P_MRD, P_MWR, P_WBR, P_WBI, P_WBM, P_HALT} phase_t;

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [3:0] model_ret = '0;
    phase_t     q_ph[$];
    bit         q_rdy[$];
    logic [31:0] r;
    logic [31:0] ins;
    logic [5:0]  fn_pick;
    int          kind;
    int          fw;
    int          mw;

    logic [14:0] obs;
    assign obs = {bus.mem_req, bus.memwrite, bus.iord, bus.ir_write, bus.pc_write, bus.alusrca,
                  bus.alusrcb, bus.op, bus.regwrite, bus.regdst, bus.mem2reg};

    function automatic bit legal_fn(input logic [5:0] fn);
        return fn inside {6'h20, 6'h24, 6'h25, 6'h22, 6'h2A};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h24:   return 3'b100;
            6'h25:   return 3'b010;
            6'h22:   return 3'b011;
            6'h2A:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [14:0] exp_vec(input phase_t p, input bit rdy, input logic [2:0] aop);
        logic mreq = 0, mwr = 0, iord = 0, irw = 0, pcw = 0, asa = 0, rw = 0, rd = 0, m2r = 0;
        logic [1:0] asb = 2'b00;
        logic [2:0] o = 3'b000;
        case (p)
            P_FETCH: begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            P_EXR:   begin asa = 1; asb = 2'b00; o = aop; end
            P_EXI,
            P_ADDR:  begin asa = 1; asb = 2'b10; end
            P_MRD:   begin mreq = 1; iord = 1; end
            P_MWR:   begin mreq = 1; iord = 1; mwr = 1; end
            P_WBR:   begin rw = 1; rd = 1; end
            P_WBI:   begin rw = 1; end
            P_WBM:   begin rw = 1; m2r = 1; end
            default: ;
        endcase
        return {mreq, mwr, iord, irw, pcw, asa, asb, o, rw, rd, m2r};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // w = number of stalled cycles before mem_ready; w >= TO means the request times out.
    task automatic push_mem(input phase_t p, input int w, output bit timed_out);
        timed_out = 1'b0;
        for (int i = 0; i < w && i < TO; i++) begin
            q_ph.push_back(p);
            q_rdy.push_back(1'b0);
        end
        if (w >= TO) timed_out = 1'b1;
        else begin
            q_ph.push_back(p);
            q_rdy.push_back(1'b1);
        end
    endtask

    // Called and returns at posedge+1 with rst released and the DUT in FETCH.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check({tag, "_rst_vec"}, 32'(obs), 32'd0);
        check({tag, "_rst_retired"}, 32'(bus.retired), 32'd0);
        check({tag, "_rst_flags"}, {30'd0, bus.illegal, bus.bus_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_ret = '0;
    endtask

    task automatic run_instr(input logic [31:0] ins_i, input int fw_i, input int mw_i, input string tag);
        bit ret = 0, ill = 0, berr = 0;
        logic [5:0] opc;
        logic [5:0] fn;
        opc = ins_i[31:26];
        fn  = ins_i[5:0];
        q_ph.delete();
        q_rdy.delete();
        push_mem(P_FETCH, fw_i, berr);
        if (!berr) begin
            q_ph.push_back(P_DEC); q_rdy.push_back(1'b0);
            if (opc == 6'h00 && legal_fn(fn)) begin
                q_ph.push_back(P_EXR); q_rdy.push_back(1'b0);
                q_ph.push_back(P_WBR); q_rdy.push_back(1'b0);
                ret = 1;
            end else if (opc == 6'h08) begin
                q_ph.push_back(P_EXI); q_rdy.push_back(1'b0);
                q_ph.push_back(P_WBI); q_rdy.push_back(1'b0);
                ret = 1;
            end else if (opc == 6'h23) begin
                q_ph.push_back(P_ADDR); q_rdy.push_back(1'b0);
                push_mem(P_MRD, mw_i, berr);
                if (!berr) begin
                    q_ph.push_back(P_WBM); q_rdy.push_back(1'b0);
                    ret = 1;
                end
            end else if (opc == 6'h2B) begin
                q_ph.push_back(P_ADDR); q_rdy.push_back(1'b0);
                push_mem(P_MWR, mw_i, berr);
                ret = !berr;
            end else begin
                ill = 1;
            end
        end
        if (ill || berr) begin
            repeat (3) begin q_ph.push_back(P_HALT); q_rdy.push_back(1'b0); end
        end

        bus.instr = ins_i;
        foreach (q_ph[i]) begin
            if (q_ph[i] inside {P_FETCH, P_MRD, P_MWR}) bus.mem_ready = q_rdy[i];
            else bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("%s_cyc%0d", tag, i), 32'(obs), 32'(exp_vec(q_ph[i], q_rdy[i], alu_of(fn))));
            @(posedge clk);
            #1;
        end
        if (ret) model_ret = model_ret + 4'd1;
        check({tag, "_retired"}, 32'(bus.retired), 32'(model_ret));
        check({tag, "_illegal"}, 32'(bus.illegal), 32'(ill));
        check({tag, "_bus_err"}, 32'(bus.bus_err), 32'(berr));
        if (ill || berr) do_reset(tag);
    endtask

    initial begin
        bus.instr     = '0;
        bus.mem_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("init_vec", 32'(obs), 32'd0);
        check("init_retired", 32'(bus.retired), 32'd0);
        check("init_flags", {30'd0, bus.illegal, bus.bus_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(32'h00221820, 0, 0, "t1_add");
        run_instr(32'h8C220004, 0, 3, "t2_lw_wait3");
        run_instr(32'hAC220008, 0, 0, "t3_sw");
        run_instr(32'h00221824, 1, 0, "and");
        run_instr(32'h00221825, 0, 0, "or");
        run_instr(32'h00221822, 2, 0, "sub");
        run_instr(32'h0022182A, 0, 0, "slt");
        run_instr(32'h2022FFFF, 0, 0, "addi");
        run_instr(32'h08000000, 0, 0, "t4_illegal_opc");
        run_instr(32'h00000021, 0, 0, "t4_illegal_fn");
        run_instr(32'h00221820, 4, 0, "t5_fetch_timeout");
        run_instr(32'h00221820, 3, 0, "t5_fetch_last_cycle");
        run_instr(32'h8C220004, 0, 4, "t5_memrd_timeout");
        run_instr(32'hAC220008, 1, 3, "sw_last_cycle");
        run_instr(32'hAC220008, 0, 5, "sw_timeout");

        for (int k = 0; k < 18; k++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: begin ins = {6'h00, r[25:6], 6'h20}; end
                1: begin ins = {6'h08, r[25:0]}; end
                2: begin ins = {6'h23, r[25:0]}; end
                default: begin ins = {6'h2B, r[25:0]}; end
            endcase
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("wrap%0d", k));
        end

        for (int k = 0; k < 60; k++) begin
            r = $urandom;
            kind = $urandom_range(0, 9);
            fn_pick = 6'($urandom_range(0, 63));
            case (kind)
                0, 1, 9: begin
                    case ($urandom_range(0, 4))
                        0: fn_pick = 6'h20;
                        1: fn_pick = 6'h24;
                        2: fn_pick = 6'h25;
                        3: fn_pick = 6'h22;
                        default: fn_pick = 6'h2A;
                    endcase
                    ins = {6'h00, r[25:6], fn_pick};
                end
                2: ins = {6'h08, r[25:0]};
                3, 4: ins = {6'h23, r[25:0]};
                5, 6: ins = {6'h2B, r[25:0]};
                7: ins = {6'h00, r[25:6], fn_pick};
                default: ins = {6'($urandom_range(0, 63)), r[25:0]};
            endcase
            fw = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
            mw = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
            run_instr(ins, fw, mw, $sformatf("rnd%0d", k));
        end

        // Reset asserted while a store is waiting in MEMWR.
        run_instr(32'h00221820, 0, 0, "t6_pre");
        bus.instr     = 32'hAC220008;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_memwr_vec", 32'(obs), 32'(exp_vec(P_MWR, 1'b0, 3'b000)));
        #2;
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check("t6_rst_vec", 32'(obs), 32'd0);
        check("t6_rst_retired", 32'(bus.retired), 32'd0);
        check("t6_rst_flags", {30'd0, bus.illegal, bus.bus_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_ret = '0;
        run_instr(32'h00221820, 0, 0, "t6_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
